sram_req_arbiter: RTL and testbench

Shares one SRAM-like memory port between the instruction-fetch requester (pre-IF/IF) and the data requester (EXE/MEM). It sits between the CPU pipeline and the AXI bridge. It grants one request per cycle and locks the grant until the address handshake completes. It also tracks in-order outstanding transactions so that each data_ok/rdata returns to the master that issued it.

---
 rtl/sram_req_arbiter_pkg.sv | 22 ++
 rtl/sram_req_arbiter_tag_fifo.sv | 67 ++++++
 rtl/sram_req_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_req_arbiter_pkg
// Shared constants and types for the SRAM-like request arbiter.
//   SRAM_REQ_BUS_WD : width of a packed request {wr, size, addr, wstrb, wdata}
//   TAG_INST/DATA   : master tag stored per outstanding transaction
//   state_t         : arbiter FSM states
// -----------------------------------------------------------------------------
package sram_req_arbiter_pkg;

   localparam int SRAM_REQ_BUS_WD = 1 + 2 + 32 + 4 + 32;  // 71

   localparam logic TAG_INST = 1'b0;
   localparam logic TAG_DATA = 1'b1;

   typedef logic [SRAM_REQ_BUS_WD-1:0] req_bus_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

endpackage : sram_req_arbiter_pkg

// File: rtl/sram_req_arbiter_tag_fifo.sv
// -----------------------------------------------------------------------------
// tag_fifo
// Small synchronous FIFO holding the master tag of each accepted, not yet
// answered transaction. Push while full and pop while empty are ignored.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write one entry
//   pop, dout  : dout shows the head; pop removes it
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module tag_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_do_push;
   logic w_do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
      end
   end

   // NOTE: the storage array is deliberately not reset; validity is defined by
   // the pointers and count alone, which keeps the array a plain RAM.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = (r_count == CNT_W'(DEPTH));
   assign empty = (r_count == '0);

endmodule : tag_fifo

// File: rtl/sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// sram_req_arbiter
// Shares one SRAM-like port between the instruction and data requesters.
// One request is granted per cycle; an unaccepted grant is locked until
// mem_addr_ok. Accepted transactions are tagged in order so each response is
// routed back to the master that issued it.
//   clk, reset                  : clock, synchronous active-high reset
//   inst_* / data_* (inputs)    : request valid and fields per master
//   inst_* / data_* (outputs)   : addr_ok, data_ok, rdata per master
//   mem_* (outputs)             : shared request, muxed from the granted master
//   mem_addr_ok/data_ok/rdata   : shared handshake and in-order response
// -----------------------------------------------------------------------------
module sram_req_arbiter
   import sram_req_arbiter_pkg::*;
#(
   parameter int OUTSTANDING = 2,
   parameter int STREAK_MAX  = 4
) (
   input  logic        clk,
   input  logic        reset,
   // instruction master
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   // data master
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   // shared memory port
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int STREAK_W = $clog2(STREAK_MAX + 1);
   localparam int ORPH_W   = $clog2(OUTSTANDING + 1);

   state_t              r_state;
   logic                r_grant;
   logic [STREAK_W-1:0] r_streak;
   logic [ORPH_W-1:0]   r_orphans;

   state_t   w_state_nxt;
   logic     w_req;
   logic     w_sel;
   logic     w_pick_inst;
   logic     w_accept;
   logic     w_pop;
   logic     w_head;
   logic     w_full;
   logic     w_empty;
   req_bus_t w_inst_bus;
   req_bus_t w_data_bus;
   req_bus_t w_mem_bus;

   assign w_inst_bus = {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
   assign w_data_bus = {data_wr, data_size, data_addr, data_wstrb, data_wdata};

   // Data has priority, except that a waiting inst request is forced through
   // once data has won STREAK_MAX times in a row against it.
   assign w_pick_inst = inst_req && (!data_req || (r_streak == STREAK_W'(STREAK_MAX)));

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_sel       = TAG_DATA;
      case (r_state)
         ST_IDLE: begin
            w_sel = w_pick_inst ? TAG_INST : TAG_DATA;
            w_req = !w_full && (inst_req || data_req);
            if (w_req && !mem_addr_ok) w_state_nxt = ST_LOCK;
         end
         ST_LOCK: begin
            // LOCK is only entered with room in the FIFO, so it ignores w_full.
            w_sel = r_grant;
            w_req = 1'b1;
            if (mem_addr_ok) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (reset) w_req = 1'b0;
   end

   assign w_accept = w_req && mem_addr_ok;
   assign w_pop    = mem_data_ok && !w_empty && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_grant  <= TAG_INST;
         r_streak <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && w_req && !mem_addr_ok) r_grant <= w_sel;
         if (!inst_req)
            r_streak <= '0;
         else if (w_accept && w_sel == TAG_INST)
            r_streak <= '0;
         else if (w_accept && r_streak != STREAK_W'(STREAK_MAX))
            r_streak <= r_streak + STREAK_W'(1);
      end
   end

   tag_fifo #(
      .DEPTH (OUTSTANDING),
      .WIDTH (1)
   ) u_tag_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_accept),
      .pop   (w_pop),
      .din   (w_sel),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   assign w_mem_bus = w_req ? ((w_sel == TAG_INST) ? w_inst_bus : w_data_bus) : '0;
   assign {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata} = w_mem_bus;
   assign mem_req = w_req;

   assign inst_addr_ok = w_accept && (w_sel == TAG_INST);
   assign data_addr_ok = w_accept && (w_sel == TAG_DATA);
   assign inst_data_ok = w_pop && (w_head == TAG_INST);
   assign data_data_ok = w_pop && (w_head == TAG_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   // Responses to transactions that were in flight across a reset arrive with
   // an empty FIFO and are dropped. Up to OUTSTANDING such stragglers are
   // tolerated after each reset; any other response with nothing outstanding
   // indicates a protocol error on the memory side.
   always_ff @(posedge clk) begin
      if (reset)
         r_orphans <= ORPH_W'(OUTSTANDING);
      else if (mem_data_ok && w_empty && r_orphans != '0)
         r_orphans <= r_orphans - ORPH_W'(1);
   end

   a_no_stray_data_ok : assert property (
      @(posedge clk) disable iff (reset)
      !(mem_data_ok && w_empty && r_orphans == '0)
   ) else $error("mem_data_ok received with no outstanding transaction");

endmodule : sram_req_arbiter

// File: tb/tb_sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_req_arbiter
// Self-checking bench: a table of single-cycle arbitration vectors followed by
// hand-written multi-cycle sequences. Expected response routing is queued when
// the bench grants an address handshake and checked when it returns data.
// -----------------------------------------------------------------------------
module tb_sram_req_arbiter;

   localparam logic TAG_I = 1'b0;
   localparam logic TAG_D = 1'b1;
   localparam logic [31:0] INST_ADDR = 32'h1c00_0000;
   localparam logic [31:0] DATA_ADDR = 32'h1c00_0100;

   logic        clk;
   logic        reset;
   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_wdata;
   logic [3:0]  inst_wstrb;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;

   sram_req_arbiter #(.OUTSTANDING(2), .STREAK_MAX(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_wr      (inst_wr),
      .inst_size    (inst_size),
      .inst_addr    (inst_addr),
      .inst_wstrb   (inst_wstrb),
      .inst_wdata   (inst_wdata),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wstrb   (data_wstrb),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_size     (mem_size),
      .mem_addr     (mem_addr),
      .mem_wstrb    (mem_wstrb),
      .mem_wdata    (mem_wdata),
      .mem_addr_ok  (mem_addr_ok),
      .mem_data_ok  (mem_data_ok),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic        tag;
      logic [31:0] rdata;
   } exp_t;
   exp_t sb[$];
   logic [31:0] rd_seq = 32'ha500_0000;

   typedef struct {
      logic        rst;
      logic        ireq;
      logic        dreq;
      logic        aok;
      logic        e_req;
      logic        e_iok;
      logic        e_dok;
      logic [31:0] e_addr;
      logic        e_wr;
   } vec_t;
   vec_t vt[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = INST_ADDR;
      inst_wstrb = 4'h0; inst_wdata = 32'h0;
      data_req = 0; data_wr = 1; data_size = 2'd2; data_addr = DATA_ADDR;
      data_wstrb = 4'hf; data_wdata = 32'hdead_beef;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
   endtask

   task automatic do_reset();
      reset = 1;
      clear_inputs();
      tick();
      reset = 0;
   endtask

   task automatic push_exp(input logic tag, input logic [31:0] rdata);
      exp_t e;
      e.tag   = tag;
      e.rdata = rdata;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] next_rd();
      rd_seq = rd_seq + 32'h11;
      return rd_seq;
   endfunction

   // Drives one response from the scoreboard head and checks its routing;
   // the caller advances the clock.
   task automatic respond_check(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, no expected response", name);
         return;
      end
      e = sb.pop_front();
      mem_data_ok = 1;
      mem_rdata   = e.rdata;
      settle();
      check({name, ".inst_data_ok"}, inst_data_ok, e.tag == TAG_I);
      check({name, ".data_data_ok"}, data_data_ok, e.tag == TAG_D);
      if (e.tag == TAG_I) check({name, ".inst_rdata"}, inst_rdata, e.rdata);
      else                check({name, ".data_rdata"}, data_rdata, e.rdata);
   endtask

   task automatic respond(input string name);
      respond_check(name);
      tick();
      mem_data_ok = 0;
      mem_rdata   = 32'h0;
   endtask

   initial begin
      // rst ireq dreq aok | req iok dok addr wr
      vt[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0};
      vt[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, INST_ADDR, 1'b0};
      vt[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, DATA_ADDR, 1'b1};
      vt[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, DATA_ADDR, 1'b1};
      vt[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, DATA_ADDR, 1'b1};
      vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, INST_ADDR, 1'b0};
      vt[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0};

      // ---- reset state ----
      reset = 1;
      clear_inputs();
      inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
      repeat (2) tick();
      check("rst.mem_req", mem_req, 0);
      check("rst.inst_addr_ok", inst_addr_ok, 0);
      check("rst.data_addr_ok", data_addr_ok, 0);
      check("rst.inst_data_ok", inst_data_ok, 0);
      check("rst.data_data_ok", data_data_ok, 0);
      do_reset();
      settle();
      check("post_rst.mem_req", mem_req, 0);

      // ---- single-cycle arbitration table ----
      for (int i = 0; i < 7; i++) begin
         do_reset();
         reset       = vt[i].rst;
         inst_req    = vt[i].ireq;
         data_req    = vt[i].dreq;
         mem_addr_ok = vt[i].aok;
         settle();
         check($sformatf("vec%0d.mem_req", i), mem_req, vt[i].e_req);
         check($sformatf("vec%0d.inst_addr_ok", i), inst_addr_ok, vt[i].e_iok);
         check($sformatf("vec%0d.data_addr_ok", i), data_addr_ok, vt[i].e_dok);
         check($sformatf("vec%0d.mem_addr", i), mem_addr, vt[i].e_addr);
         check($sformatf("vec%0d.mem_wr", i), mem_wr, vt[i].e_wr);
      end

      // ---- 1: inst only ----
      do_reset();
      inst_req = 1; mem_addr_ok = 1;
      settle();
      check("t1.inst_addr_ok", inst_addr_ok, 1);
      check("t1.mem_addr", mem_addr, INST_ADDR);
      push_exp(TAG_I, 32'h0280_0000);
      tick();
      inst_req = 0; mem_addr_ok = 0;
      settle();
      check("t1.c1_inst_addr_ok", inst_addr_ok, 0);
      check("t1.c1_inst_data_ok", inst_data_ok, 0);
      tick();
      respond("t1.resp");

      // ---- 2: simultaneous requests ----
      do_reset();
      inst_req = 1; data_req = 1; mem_addr_ok = 1;
      settle();
      check("t2.data_addr_ok", data_addr_ok, 1);
      check("t2.inst_addr_ok", inst_addr_ok, 0);
      check("t2.mem_addr", mem_addr, DATA_ADDR);
      check("t2.mem_wstrb", mem_wstrb, 4'hf);
      check("t2.mem_wdata", mem_wdata, 32'hdead_beef);
      push_exp(TAG_D, next_rd());
      tick();
      data_req = 0;
      settle();
      check("t2.c1_inst_addr_ok", inst_addr_ok, 1);
      check("t2.c1_mem_addr", mem_addr, INST_ADDR);
      push_exp(TAG_I, next_rd());
      tick();
      inst_req = 0; mem_addr_ok = 0;
      respond("t2.resp_data");
      respond("t2.resp_inst");

      // ---- 3: grant lock ----
      do_reset();
      data_req = 1;
      for (int c = 0; c < 3; c++) begin
         settle();
         check($sformatf("t3.c%0d_mem_req", c), mem_req, 1);
         check($sformatf("t3.c%0d_mem_addr", c), mem_addr, DATA_ADDR);
         check($sformatf("t3.c%0d_inst_addr_ok", c), inst_addr_ok, 0);
         check($sformatf("t3.c%0d_data_addr_ok", c), data_addr_ok, 0);
         tick();
         inst_req = 1;
      end
      mem_addr_ok = 1;
      settle();
      check("t3.accept_data_addr_ok", data_addr_ok, 1);
      check("t3.accept_inst_addr_ok", inst_addr_ok, 0);
      check("t3.accept_mem_addr", mem_addr, DATA_ADDR);
      push_exp(TAG_D, next_rd());
      tick();
      data_req = 0;
      settle();
      check("t3.inst_addr_ok", inst_addr_ok, 1);
      push_exp(TAG_I, next_rd());
      tick();
      inst_req = 0; mem_addr_ok = 0;
      respond("t3.resp_data");
      respond("t3.resp_inst");

      // ---- 4: FIFO full ----
      do_reset();
      data_req = 1; mem_addr_ok = 1;
      for (int c = 0; c < 2; c++) begin
         settle();
         check($sformatf("t4.acc%0d_data_addr_ok", c), data_addr_ok, 1);
         push_exp(TAG_D, next_rd());
         tick();
      end
      settle();
      check("t4.full_mem_req", mem_req, 0);
      check("t4.full_data_addr_ok", data_addr_ok, 0);
      tick();
      respond_check("t4.pop");
      check("t4.pop_cycle_mem_req", mem_req, 0);
      check("t4.pop_cycle_data_addr_ok", data_addr_ok, 0);
      tick();
      mem_data_ok = 0;
      settle();
      check("t4.after_pop_mem_req", mem_req, 1);
      check("t4.after_pop_data_addr_ok", data_addr_ok, 1);
      push_exp(TAG_D, next_rd());
      tick();
      data_req = 0; mem_addr_ok = 0;
      respond("t4.drain0");
      respond("t4.drain1");

      // ---- 5: starvation guard ----
      do_reset();
      inst_req = 1; data_req = 1; mem_addr_ok = 1;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) respond_check($sformatf("t5.resp%0d", k));
         else       settle();
         check($sformatf("t5.k%0d_inst_addr_ok", k), inst_addr_ok, (k % 5) == 4);
         check($sformatf("t5.k%0d_data_addr_ok", k), data_addr_ok, (k % 5) != 4);
         push_exp(((k % 5) == 4) ? TAG_I : TAG_D, next_rd());
         tick();
         mem_data_ok = 0;
      end
      inst_req = 0; data_req = 0; mem_addr_ok = 0;
      respond("t5.last");

      // ---- 6: reset mid-flight ----
      do_reset();
      data_req = 1; mem_addr_ok = 1;
      for (int c = 0; c < 2; c++) begin
         settle();
         check($sformatf("t6.acc%0d_data_addr_ok", c), data_addr_ok, 1);
         tick();
      end
      reset = 1; mem_data_ok = 1; mem_rdata = 32'h1234_5678;
      settle();
      check("t6.rst_mem_req", mem_req, 0);
      check("t6.rst_data_addr_ok", data_addr_ok, 0);
      check("t6.rst_data_data_ok", data_data_ok, 0);
      check("t6.rst_inst_data_ok", inst_data_ok, 0);
      tick();
      reset = 0; data_req = 0; mem_addr_ok = 0;
      for (int c = 0; c < 2; c++) begin
         settle();
         check($sformatf("t6.stray%0d_data_data_ok", c), data_data_ok, 0);
         check($sformatf("t6.stray%0d_inst_data_ok", c), inst_data_ok, 0);
         tick();
      end
      mem_data_ok = 0; mem_rdata = 32'h0;
      inst_req = 1; mem_addr_ok = 1;
      settle();
      check("t6.new_inst_addr_ok", inst_addr_ok, 1);
      check("t6.new_mem_addr", mem_addr, INST_ADDR);
      push_exp(TAG_I, next_rd());
      tick();
      inst_req = 0; mem_addr_ok = 0;
      respond("t6.resp");

      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_sram_req_arbiter
